// File: rtl/asdpmem_fifo.sv
// Single-clock FIFO around an asdpmem (async-read dual-port RAM) with a registered output word.
// Define ASDPMEM_FIFO_AFULL_EN to add the registered almost_full output (threshold AFULL_THRESH).
`timescale 1ns/1ps

module asdpmem #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 32
) (
  input  logic             clka,
  input  logic             ena,
  input  logic             wea,
  input  logic [DEPTH-1:0] addra,
  input  logic [WIDTH-1:0] dia,
  input  logic [DEPTH-1:0] addrb,
  output logic [WIDTH-1:0] dob
);
  logic [WIDTH-1:0] mem [0:(2**DEPTH)-1];

  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dia;
  end

  assign dob = mem[addrb];
endmodule

module asdpmem_fifo #(
  parameter int DEPTH        = 6,
  parameter int WIDTH        = 32,
  parameter int AFULL_THRESH = 60
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic             empty
`ifdef ASDPMEM_FIFO_AFULL_EN
  ,
  output logic             almost_full
`endif
);
  localparam int unsigned   WORDS     = 2**DEPTH;
  localparam logic [DEPTH:0] MEM_FULL  = WORDS[DEPTH:0];
  localparam logic [DEPTH:0] FIFO_FULL = MEM_FULL + {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH:0] ONE       = {{DEPTH{1'b0}}, 1'b1};

  logic [DEPTH:0]   wptr, rptr, wptr_n, rptr_n, mem_cnt;
  logic             out_valid_n, push, load;
  logic [WIDTH-1:0] out_data_n, dob;

  asdpmem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clka  (clk),
    .ena   (1'b1),
    .wea   (push),
    .addra (wptr[DEPTH-1:0]),
    .dia   (in_data),
    .addrb (rptr[DEPTH-1:0]),
    .dob   (dob)
  );

  assign mem_cnt  = wptr - rptr;
  // A slot freed by a load this cycle is only offered to the producer next cycle.
  assign in_ready = (mem_cnt != MEM_FULL) && !srst;
  assign push     = in_valid && in_ready;
  assign load     = (mem_cnt != '0) && (!out_valid || out_ready);
  assign count    = mem_cnt + {{DEPTH{1'b0}}, out_valid};
  assign full     = (count == FIFO_FULL);
  assign empty    = (count == '0);

  always_comb begin
    wptr_n      = wptr;
    rptr_n      = rptr;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    if (push) wptr_n = wptr + ONE;
    if (load) begin
      rptr_n      = rptr + ONE;
      out_valid_n = 1'b1;
      out_data_n  = dob;
    end else if (out_ready && out_valid) begin
      out_valid_n = 1'b0;
    end
  end

  // Memory contents survive reset; equal pointers keep stale words hidden.
  always_ff @(posedge clk) begin
    if (srst) begin
      wptr      <= '0;
      rptr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

`ifdef ASDPMEM_FIFO_AFULL_EN
  localparam logic [DEPTH:0] AF_T = AFULL_THRESH[DEPTH:0];
  logic [DEPTH:0] count_n;
  assign count_n = (wptr_n - rptr_n) + {{DEPTH{1'b0}}, out_valid_n};

  always_ff @(posedge clk) begin
    if (srst) almost_full <= 1'b0;
    else      almost_full <= (count_n >= AF_T);
  end
`endif
endmodule
